alu_exec_unit: RTL and testbench

//   Multi-cycle execute unit: the consumer of the 3-bit ALUControl code made by the ALU decoder.

---
 rtl/alu_exec_unit.sv | 132 +++++++++++++
 tb/tb_alu_exec_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: takes A/B and a 3-bit ALU code, produces the result DIGIT bits
// per cycle (LSB first, carry chained between chunks), then returns the result and N/Z/C/V flags.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready high
  // BUSY  | processing one DIGIT-wide chunk per cycle
  // DONE  | result and flags presented until out_ready

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg, acc;
  logic [2:0]       code_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt;

  logic             accept, last, sub_in, is_logic, is_slt;
  logic [DIGIT-1:0] a_k, b_k, s_k, r_k;
  logic             c_k, sum_msb, v_raw;
  logic [WIDTH-1:0] full, res_nx;

  assign accept   = in_valid & in_ready;
  assign last     = (cnt == LAST);
  assign sub_in   = (alu_control == OP_SUB) || (alu_control == OP_SLT);
  assign is_logic = (code_reg == OP_AND) || (code_reg == OP_OR);
  assign is_slt   = (code_reg == OP_SLT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Chunk datapath; upper chunks of acc may be stale, but each is overwritten before the last edge.
  always_comb begin
    a_k      = a_reg[cnt*DIGIT +: DIGIT];
    b_k      = b_reg[cnt*DIGIT +: DIGIT];
    {c_k, s_k} = {1'b0, a_k} + {1'b0, b_k} + {{DIGIT{1'b0}}, carry_reg};
    case (code_reg)
      OP_AND:  r_k = a_k & b_k;
      OP_OR:   r_k = a_k | b_k;
      default: r_k = s_k;
    endcase
    full = acc;
    full[cnt*DIGIT +: DIGIT] = r_k;
    sum_msb = full[WIDTH-1];
    v_raw   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_msb != a_reg[WIDTH-1]);
    res_nx  = is_slt ? {{(WIDTH-1){1'b0}}, sum_msb ^ v_raw} : full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      code_reg  <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_reg     <= src_a;
      b_reg     <= sub_in ? ~src_b : src_b;
      code_reg  <= alu_control;
      carry_reg <= sub_in;
      cnt       <= '0;
    end else if (state == BUSY) begin
      acc       <= full;
      carry_reg <= c_k;
      cnt       <= cnt + CW'(1);
      if (last) begin
        result   <= res_nx;
        zero     <= (res_nx == '0);
        negative <= res_nx[WIDTH-1];
        carry    <= is_logic ? 1'b0 : c_k;
        overflow <= is_logic ? 1'b0 : v_raw;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: randomized and directed operations against an arithmetic
// reference model, plus a DIGIT=WIDTH instance for single-cycle latency.
module tb_alu_exec_unit;
  localparam int W      = 32;
  localparam int NCHUNK = 4;

  logic          clk, rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  src_a, src_b, result;
  logic [2:0]    alu_control;
  logic          zero, negative, carry, overflow, busy;

  logic          iv32, ir32, ov32;
  logic [W-1:0]  a32, b32, res32;
  logic [2:0]    c32;
  logic          z32, n32, cy32, v32, busy32;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int rmode = 0;

  logic [W+3:0] exp_q[$];
  int           acc_q[$];

  alu_exec_unit #(.WIDTH(W), .DIGIT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow), .busy(busy));

  alu_exec_unit #(.WIDTH(W), .DIGIT(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .src_a(a32), .src_b(b32), .alu_control(c32),
    .out_valid(ov32), .out_ready(1'b1), .result(res32),
    .zero(z32), .negative(n32), .carry(cy32), .overflow(v32), .busy(busy32));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {result, N, Z, C, V} from plain integer arithmetic
  function automatic logic [W+3:0] model(input logic [W-1:0] a, b, input logic [2:0] code);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    case (code)
      3'b010: begin r = a & b; c = 1'b0; v = 1'b0; end
      3'b011: begin r = a | b; c = 1'b0; v = 1'b0; end
      3'b001, 3'b101: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        c = s[W];
        v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        if (code == 3'b101) r = ($signed(a) < $signed(b)) ? 1 : 0;
        else                r = s[W-1:0];
      end
      default: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[W];
        v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        r = s[W-1:0];
      end
    endcase
    return {r, r[W-1], (r == 0), c, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  task automatic issue(input logic [W-1:0] a, b, input logic [2:0] code);
    int n = 0;
    @(negedge clk);
    src_a = a; src_b = b; alu_control = code; in_valid = 1'b1;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (!in_ready) begin fail("accept_timeout"); in_valid = 1'b0; return; end
    @(posedge clk);
    #1;
    exp_q.push_back(model(a, b, code));
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    src_a = $urandom; src_b = $urandom; alu_control = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) fail("drain_timeout");
  endtask

  task automatic run32(input logic [W-1:0] a, b, input logic [2:0] code);
    int n = 0;
    @(negedge clk);
    a32 = a; b32 = b; c32 = code; iv32 = 1'b1;
    while (!ir32 && n < 50) begin @(negedge clk); n++; end
    chk("d32_accept", ir32, 1);
    @(posedge clk);
    #1 iv32 = 1'b0;
    chk("d32_not_early", ov32, 0);
    @(posedge clk);
    #1;
    chk("d32_latency", ov32, 1);
    chk("d32_result_flags", {res32, n32, z32, cy32, v32}, model(a, b, code));
  endtask

  // Consumer readiness changes just after the rising edge, so it is stable at the monitor's sample.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  logic         prev_ov = 1'b0, prev_pend = 1'b0;
  logic [W+3:0] last_cur = '0, cur, e;
  int           a_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_out_valid", out_valid, 0);
      prev_ov = 1'b0;
      prev_pend = 1'b0;
    end else begin
      cur = {result, negative, zero, carry, overflow};
      if (prev_pend) chk("valid_held", out_valid, 1);
      if (out_valid) begin
        chk("done_in_ready", in_ready, 0);
        if (!prev_ov) begin
          if (acc_q.size() == 0) fail("unexpected_output");
          else begin
            a_cyc = acc_q.pop_front();
            chk("latency", 64'(cyc - a_cyc), NCHUNK);
          end
        end
        if (prev_pend) chk("hold_stable", cur, last_cur);
        if (out_ready) begin
          if (exp_q.size() == 0) fail("unexpected_result");
          else begin
            e = exp_q.pop_front();
            chk("result_flags", cur, e);
          end
        end
      end
      prev_ov   = out_valid;
      prev_pend = out_valid && !out_ready;
      last_cur  = cur;
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; src_a = '0; src_b = '0; alu_control = '0;
    iv32 = 1'b0; a32 = '0; b32 = '0; c32 = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset_result", {result, negative, zero, carry, overflow}, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("reset_in_ready", in_ready, 1);

    // directed cases
    issue(32'h7FFFFFFF, 32'h00000001, 3'b000);
    issue(32'd5, 32'd5, 3'b001);
    issue(32'h000000FF, 32'h00000001, 3'b000);
    issue(32'hFFFFFFFF, 32'h00000001, 3'b101);
    issue(32'h00000001, 32'hFFFFFFFF, 3'b101);
    issue(32'h80000000, 32'h00000001, 3'b101);
    issue(32'hF0F0F0F0, 32'h0FF00FF0, 3'b010);
    issue(32'hF0F0F0F0, 32'h0FF00FF0, 3'b011);
    issue(32'd2, 32'd3, 3'b111);
    issue(32'd2, 32'd3, 3'b100);
    issue(32'd2, 32'd3, 3'b110);
    drain();

    // random ops with a random consumer
    rmode = 1;
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      issue(ra, rb, 3'($urandom));
    end
    rmode = 0;
    drain();

    // result held while the consumer stalls and new requests are offered
    rmode = 2;
    issue(32'h12345678, 32'h9ABCDEF0, 3'b001);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) fail("stall_valid_timeout");
    repeat (6) begin
      @(negedge clk);
      src_a = $urandom; src_b = $urandom; alu_control = 3'($urandom); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_still_valid", out_valid, 1);
    rmode = 0;
    drain();
    repeat (3) @(negedge clk);
    chk("stall_no_accept", busy, 0);

    // reset during the third BUSY cycle discards the operation
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midreset_outputs", {result, negative, zero, carry, overflow, out_valid, busy}, 0);
    exp_q.delete();
    acc_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk("midreset_in_ready", in_ready, 1);
    repeat (6) @(negedge clk);
    chk("midreset_no_output", out_valid, 0);
    issue(32'd1, 32'd1, 3'b000);
    drain();

    // single-chunk instance
    run32(32'h7FFFFFFF, 32'h00000001, 3'b000);
    run32(32'd5, 32'd5, 3'b001);
    run32(32'h000000FF, 32'h00000001, 3'b000);
    run32(32'hFFFFFFFF, 32'h00000001, 3'b101);
    run32(32'h00000001, 32'hFFFFFFFF, 3'b101);
    run32(32'h80000000, 32'h00000001, 3'b101);
    run32(32'hF0F0F0F0, 32'h0FF00FF0, 3'b010);
    run32(32'hF0F0F0F0, 32'h0FF00FF0, 3'b011);
    run32(32'd2, 32'd3, 3'b111);

    repeat (4) @(negedge clk);
    if (acc_q.size() != 0) fail("leftover_accepts");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
